serial_subtractor_n: RTL and testbench
======================================

Name: serial_subtractor_n

Overview:
Parametrised multi-cycle subtractor that computes A - B - borrow_in on WIDTH-bit operands, DIGIT bits per clock. It extends the single-bit full subtractor cell into a shift-based datapath with a start/busy/done handshake. Its use is area-constrained arithmetic where a full ripple-borrow chain is not wanted.

Parameters:
WIDTH, 8, operand and result width in bits; must be >= 2.
DIGIT, 1, bits processed per cycle; must divide WIDTH exactly; a failing check is a fatal elaboration error.

Ports:
clk  input  1  rising-edge clock, the only clock.
rst  input  1  synchronous reset, active-high.
start  input  1  request; sampled only in IDLE or DONE.
a  input  WIDTH  minuend, captured on the accepted start.
b  input  WIDTH  subtrahend, captured on the accepted start.
borrow_in  input  1  initial borrow, captured on the accepted start.
busy  output  1  high while in RUN.
done  output  1  one-cycle pulse; result valid.
difference  output  WIDTH  a - b - borrow_in mod 2^WIDTH.
borrow_out  output  1  final borrow; 1 iff a < b + borrow_in (unsigned).

Behaviour:
- Reset: synchronous, active-high. On any edge with rst=1: state=IDLE, busy=0, done=0, difference=0, borrow_out=0, digit counter=0, internal registers cleared. rst takes priority over every other input, including mid-RUN; a reset in RUN aborts the operation with no done pulse.
- N = WIDTH/DIGIT.
- FSM states: IDLE, RUN, DONE.
  - IDLE: if start=1 at an edge, capture a, b and borrow_in, set count=0 and go to RUN.
  - RUN: at each edge, process the digit at bits [count*DIGIT +: DIGIT], LSB digit first. Write the result digit into the difference shift register and update the borrow register. At count=N-1, go to DONE; otherwise count=count+1.
  - DONE: done=1 for exactly this one cycle. If start=1 at this edge, capture new operands and go to RUN (back-to-back operation). Otherwise go to IDLE.
- Per-bit arithmetic: d = a^b^bi; bo = (~a&b) | (~(a^b)&bi). Borrow ripples through the DIGIT bits combinationally within one cycle.
- Latency: start is sampled at edge 0; done is high in the cycle after edge N. busy=1 for exactly N cycles.
- start is ignored while busy=1. Operand changes after capture have no effect.
- difference and borrow_out hold their last value from DONE through IDLE until the next capture edge. During RUN they are undefined to the consumer, who must qualify them with done.
- WIDTH=DIGIT gives N=1: a single RUN cycle, then DONE.

Optional Feature:
Macro SERIAL_SUB_OVF_EN.
- Defined: adds output port overflow (1 bit), treating operands as two's-complement signed. overflow = (a[MSB] != b[MSB]) && (difference[MSB] != a[MSB]). It is valid with done, holds with difference, and resets to 0.
- Undefined: the port does not exist and no logic is generated.

Decomposition:
- Package serial_sub_pkg contains:
  - the state encoding localparams ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2;
  - the function clog2 used for sizing the counter.
- One sub-module, sub_digit: a combinational DIGIT-wide borrow-ripple slice.
  - Inputs: a_d, b_d, bi.
  - Outputs: d_d, bo.
  - Built from per-bit subtractor equations and instantiated once.

Test Plan:
1. WIDTH=8, DIGIT=1: a=0x05, b=0x03, borrow_in=0 -> difference=0x02, borrow_out=0; done exactly 8 cycles after the start edge; busy high for 8 cycles.
2. WIDTH=8: a=0x00, b=0x01, borrow_in=0 -> difference=0xFF, borrow_out=1. Then a=0x10, b=0x0F, borrow_in=1 -> difference=0x00, borrow_out=0.
3. WIDTH=8, DIGIT=4: a=0x3C, b=0x0F -> difference=0x2D, borrow_out=0, done 2 cycles after start.
4. Back-to-back: start held high continuously -> second operation is captured in the DONE cycle with no IDLE gap. A start pulse during RUN is ignored and the result is unchanged.
5. Reset mid-operation: rst=1 at RUN count=3 -> next cycle busy=0, done=0, difference=0, borrow_out=0, and no later done pulse. A subsequent start runs normally.
6. With SERIAL_SUB_OVF_EN: a=0x80, b=0x01 -> difference=0x7F, overflow=1. a=0x05, b=0x03 -> overflow=0. Compile without the macro and confirm the port is absent.

Source files
------------

// File: rtl/serial_sub_pkg.sv
// Shared state encoding and the sizing helper for the serial subtractor.
package serial_sub_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        for (int unsigned v = (value > 0) ? value - 1 : 0; v > 0; v = v >> 1) begin
            result++;
        end
        return result;
    endfunction

endpackage

// File: rtl/sub_digit.sv
// Combinational DIGIT-wide slice: per-bit full subtractors with the borrow rippling LSB to MSB.
module sub_digit #(
    parameter int unsigned DIGIT = 1
) (
    input  logic [DIGIT-1:0] a_d,
    input  logic [DIGIT-1:0] b_d,
    input  logic             bi,
    output logic [DIGIT-1:0] d_d,
    output logic             bo
);

    logic c;

    always_comb begin
        c   = bi;
        d_d = '0;
        for (int i = 0; i < DIGIT; i++) begin
            d_d[i] = a_d[i] ^ b_d[i] ^ c;
            c      = (~a_d[i] & b_d[i]) | (~(a_d[i] ^ b_d[i]) & c);
        end
        bo = c;
    end

endmodule

// File: rtl/serial_subtractor_n.sv
// Multi-cycle A - B - borrow_in, DIGIT bits per clock, with start/busy/done handshake.
// Define SERIAL_SUB_OVF_EN to add a signed overflow output.
module serial_subtractor_n
    import serial_sub_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             borrow_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] difference,
    output logic             borrow_out
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             overflow
`endif
);

    localparam int unsigned NumDigits = WIDTH / DIGIT;
    localparam int unsigned CntW      = (clog2(NumDigits) > 0) ? clog2(NumDigits) : 1;

    if (WIDTH < 2 || DIGIT == 0 || (WIDTH % DIGIT) != 0) begin : g_bad_cfg
        $fatal(1, "serial_subtractor_n: WIDTH must be >= 2 and a multiple of DIGIT");
    end

    typedef enum logic [1:0] {
        StIdle = ST_IDLE,
        StRun  = ST_RUN,
        StDone = ST_DONE
    } state_e;

    state_e           state_q;
    logic [CntW-1:0]  cnt_q;
    logic [WIDTH-1:0] a_q, b_q, diff_q;
    logic             borrow_q, bo_q, busy_q, done_q;
    logic [DIGIT-1:0] d_dig;
    logic             bo_dig;
    logic [WIDTH-1:0] diff_shift;
    logic             last_digit;

    sub_digit #(
        .DIGIT (DIGIT)
    ) u_sub_digit (
        .a_d (a_q[DIGIT-1:0]),
        .b_d (b_q[DIGIT-1:0]),
        .bi  (borrow_q),
        .d_d (d_dig),
        .bo  (bo_dig)
    );

    // New digit enters at the top; after NumDigits shifts the LSB digit lands at bit 0.
    assign diff_shift = (WIDTH'(d_dig) << (WIDTH - DIGIT)) | (diff_q >> DIGIT);
    assign last_digit = (cnt_q == CntW'(NumDigits - 1));

`ifdef SERIAL_SUB_OVF_EN
    logic a_msb_q, b_msb_q, ovf_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            bo_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            a_msb_q  <= 1'b0;
            b_msb_q  <= 1'b0;
            ovf_q    <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle, StDone: begin
                    if (start) begin
                        a_q      <= a;
                        b_q      <= b;
                        borrow_q <= borrow_in;
                        cnt_q    <= '0;
                        busy_q   <= 1'b1;
                        state_q  <= StRun;
`ifdef SERIAL_SUB_OVF_EN
                        a_msb_q  <= a[WIDTH-1];
                        b_msb_q  <= b[WIDTH-1];
`endif
                    end else begin
                        state_q <= StIdle;
                    end
                end
                StRun: begin
                    a_q      <= a_q >> DIGIT;
                    b_q      <= b_q >> DIGIT;
                    borrow_q <= bo_dig;
                    diff_q   <= diff_shift;
                    if (last_digit) begin
                        bo_q    <= bo_dig;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= StDone;
`ifdef SERIAL_SUB_OVF_EN
                        ovf_q   <= (a_msb_q != b_msb_q) && (diff_shift[WIDTH-1] != a_msb_q);
`endif
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign difference = diff_q;
    assign borrow_out = bo_q;
`ifdef SERIAL_SUB_OVF_EN
    assign overflow   = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor_n.sv
// Directed bench: one 8x1 instance and one 8x4 instance sharing clock, reset and operands.
module tb_serial_subtractor_n;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       sel = 1'b0;
    logic [7:0] a = '0, b = '0;
    logic       borrow_in = 1'b0;

    logic       busy0, done0, bo0, busy1, done1, bo1;
    logic [7:0] diff0, diff1;
    logic       start0, start1;
    logic       busy_s, done_s, bo_s;
    logic [7:0] diff_s;

    int total = 0;
    int passed = 0;
    int cyc, busy_cnt, pulses;

    always #5 clk = ~clk;

    assign start0 = start & ~sel;
    assign start1 = start & sel;
    assign busy_s = sel ? busy1 : busy0;
    assign done_s = sel ? done1 : done0;
    assign bo_s   = sel ? bo1 : bo0;
    assign diff_s = sel ? diff1 : diff0;

`ifdef SERIAL_SUB_OVF_EN
    logic ovf0, ovf1;
`endif

    serial_subtractor_n #(.WIDTH(8), .DIGIT(1)) dut0 (
        .clk        (clk),
        .rst        (rst),
        .start      (start0),
        .a          (a),
        .b          (b),
        .borrow_in  (borrow_in),
        .busy       (busy0),
        .done       (done0),
        .difference (diff0),
        .borrow_out (bo0)
`ifdef SERIAL_SUB_OVF_EN
        ,
        .overflow   (ovf0)
`endif
    );

    serial_subtractor_n #(.WIDTH(8), .DIGIT(4)) dut1 (
        .clk        (clk),
        .rst        (rst),
        .start      (start1),
        .a          (a),
        .b          (b),
        .borrow_in  (borrow_in),
        .busy       (busy1),
        .done       (done1),
        .difference (diff1),
        .borrow_out (bo1)
`ifdef SERIAL_SUB_OVF_EN
        ,
        .overflow   (ovf1)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Present operands and pulse start across one edge (edge 0).
    task automatic start_op(input logic [7:0] av, input logic [7:0] bv, input logic bin);
        a         = av;
        b         = bv;
        borrow_in = bin;
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    // Counts edges from the current point until done, bounded.
    task automatic wait_done();
        cyc      = 0;
        busy_cnt = 0;
        while (done_s !== 1'b1 && cyc < 40) begin
            if (busy_s === 1'b1) busy_cnt++;
            tick();
            cyc++;
        end
    endtask

    initial begin
        tick();
        tick();
        check("rst_busy", {31'd0, busy0}, 32'd0);
        check("rst_done", {31'd0, done0}, 32'd0);
        check("rst_diff", {24'd0, diff0}, 32'd0);
        check("rst_bo", {31'd0, bo0}, 32'd0);
        rst = 1'b0;
        tick();

        // 5 - 3 with full latency checks
        start_op(8'h05, 8'h03, 1'b0);
        check("t1_busy_after_start", {31'd0, busy0}, 32'd1);
        wait_done();
        check("t1_latency", cyc, 32'd8);
        check("t1_busy_cycles", busy_cnt, 32'd8);
        check("t1_diff", {24'd0, diff0}, 32'h02);
        check("t1_bo", {31'd0, bo0}, 32'd0);
        tick();
        check("t1_done_one_cycle", {31'd0, done0}, 32'd0);
        check("t1_hold_diff", {24'd0, diff0}, 32'h02);

        start_op(8'h00, 8'h01, 1'b0);
        wait_done();
        check("t2a_diff", {24'd0, diff0}, 32'hFF);
        check("t2a_bo", {31'd0, bo0}, 32'd1);

        start_op(8'h10, 8'h0F, 1'b1);
        wait_done();
        check("t2b_diff", {24'd0, diff0}, 32'h00);
        check("t2b_bo", {31'd0, bo0}, 32'd0);

        start_op(8'h00, 8'hFF, 1'b1);
        wait_done();
        check("t2c_diff", {24'd0, diff0}, 32'h00);
        check("t2c_bo", {31'd0, bo0}, 32'd1);

        // DIGIT=4 instance
        sel = 1'b1;
        start_op(8'h3C, 8'h0F, 1'b0);
        wait_done();
        check("t3_latency", cyc, 32'd2);
        check("t3_busy_cycles", busy_cnt, 32'd2);
        check("t3_diff", {24'd0, diff1}, 32'h2D);
        check("t3_bo", {31'd0, bo1}, 32'd0);
        start_op(8'h12, 8'h34, 1'b1);
        wait_done();
        check("t3b_diff", {24'd0, diff1}, 32'hDD);
        check("t3b_bo", {31'd0, bo1}, 32'd1);
        sel = 1'b0;
        tick();

        // Back-to-back with start held; operands changed right after capture
        a = 8'h20; b = 8'h01; borrow_in = 1'b0; start = 1'b1;
        tick();
        a = 8'h07; b = 8'h09;
        wait_done();
        check("t4_first_latency", cyc, 32'd8);
        check("t4_first_diff", {24'd0, diff0}, 32'h1F);
        check("t4_first_bo", {31'd0, bo0}, 32'd0);
        tick();
        start = 1'b0;
        check("t4_no_gap_busy", {31'd0, busy0}, 32'd1);
        check("t4_no_gap_done", {31'd0, done0}, 32'd0);
        wait_done();
        check("t4_second_latency", cyc, 32'd8);
        check("t4_second_diff", {24'd0, diff0}, 32'hFE);
        check("t4_second_bo", {31'd0, bo0}, 32'd1);
        tick();

        // start pulse during RUN is ignored
        start_op(8'h44, 8'h11, 1'b0);
        tick();
        tick();
        a = 8'hAA; b = 8'hBB; start = 1'b1;
        tick();
        start = 1'b0;
        wait_done();
        check("t4_ignore_latency", cyc, 32'd5);
        check("t4_ignore_diff", {24'd0, diff0}, 32'h33);
        check("t4_ignore_bo", {31'd0, bo0}, 32'd0);
        tick();
        check("t4_ignore_idle", {31'd0, busy0}, 32'd0);

        // Reset at RUN count=3
        start_op(8'hFF, 8'h00, 1'b0);
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t5_busy", {31'd0, busy0}, 32'd0);
        check("t5_done", {31'd0, done0}, 32'd0);
        check("t5_diff", {24'd0, diff0}, 32'd0);
        check("t5_bo", {31'd0, bo0}, 32'd0);
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            if (done0 === 1'b1) pulses++;
            tick();
        end
        check("t5_no_done", pulses, 32'd0);
        start_op(8'h09, 8'h04, 1'b0);
        wait_done();
        check("t5_after_latency", cyc, 32'd8);
        check("t5_after_diff", {24'd0, diff0}, 32'h05);

`ifdef SERIAL_SUB_OVF_EN
        tick();
        start_op(8'h80, 8'h01, 1'b0);
        wait_done();
        check("t6a_diff", {24'd0, diff0}, 32'h7F);
        check("t6a_ovf", {31'd0, ovf0}, 32'd1);
        tick();
        check("t6a_ovf_hold", {31'd0, ovf0}, 32'd1);
        start_op(8'h05, 8'h03, 1'b0);
        wait_done();
        check("t6b_ovf", {31'd0, ovf0}, 32'd0);
        sel = 1'b1;
        start_op(8'h7F, 8'hFF, 1'b0);
        wait_done();
        check("t6c_diff", {24'd0, diff1}, 32'h80);
        check("t6c_ovf", {31'd0, ovf1}, 32'd1);
        sel = 1'b0;
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
